// File: rtl/ahb_master_pack.sv
// ---------------------------------------------------------------------------
// ahb_master_pack
//  Shared AHB 2.0 type definitions used by the master and the SRAM responder.
//  - t_htrans / t_hsize / t_hburst / t_hresp : bus field encodings
//  - t_slv_state                             : SRAM responder data-phase FSM
//  - hsize_bytes()                           : bytes moved by one beat
// ---------------------------------------------------------------------------
package ahb_master_pack;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } t_htrans;

  typedef enum logic [2:0] {
    HSIZE_8    = 3'd0,
    HSIZE_16   = 3'd1,
    HSIZE_32   = 3'd2,
    HSIZE_64   = 3'd3,
    HSIZE_128  = 3'd4,
    HSIZE_256  = 3'd5,
    HSIZE_512  = 3'd6,
    HSIZE_1024 = 3'd7
  } t_hsize;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } t_hburst;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } t_hresp;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } t_slv_state;

  function automatic int hsize_bytes(input logic [2:0] size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// ---------------------------------------------------------------------------
// ahb_slave_ram
//  Single-port RAM, DATA_WDT wide, 2**ADDR_W words, per-byte write enable,
//  asynchronous read. Contents are never reset.
//  Ports:
//  - i_clk    clock, writes on rising edge
//  - i_we     one enable per byte lane (lane 0 = bits [7:0])
//  - i_addr   word index, shared by read and write
//  - i_wdata  write data
//  - o_rdata  read data of word i_addr (combinational)
// ---------------------------------------------------------------------------
module ahb_slave_ram #(
  parameter int DATA_WDT = 32,
  parameter int ADDR_W   = 10
) (
  input  logic                  i_clk,
  input  logic [DATA_WDT/8-1:0] i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_WDT-1:0]   i_wdata,
  output logic [DATA_WDT-1:0]   o_rdata
);

  localparam int NB    = DATA_WDT / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_WDT-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB; b++) begin
      if (i_we[b]) mem_q[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
  end

  assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/ahb_slave_sram.sv
// ---------------------------------------------------------------------------
// ahb_slave_sram
//  AHB 2.0 responder in front of a byte-addressable on-chip SRAM. Answers
//  OKAY (with WAIT_STATES stall cycles per good beat) or a two-cycle ERROR.
//  Ports:
//  - i_hclk, i_hreset  clock / synchronous active-high reset
//  - i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hready
//                      address-phase inputs (i_hready is the bus HREADY)
//  - i_hwdata          write data, taken only on the completing data cycle
//  - o_hready, o_hresp registered data-phase handshake / response
//  - o_hrdata          read word in S_DATA, zero otherwise
// ---------------------------------------------------------------------------
module ahb_slave_sram
  import ahb_master_pack::*;
#(
  parameter int          DATA_WDT    = 32,
  parameter int          MEM_BYTES   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  t_htrans             i_htrans,
  input  logic                i_hwrite,
  input  t_hsize              i_hsize,
  input  t_hburst             i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic                o_hready,
  output t_hresp              o_hresp,
  output logic [DATA_WDT-1:0] o_hrdata
);

  localparam int NB = DATA_WDT / 8;
  localparam int LB = $clog2(NB);                     // lane-select bits
  localparam int OW = $clog2(MEM_BYTES);              // in-RAM byte offset bits
  localparam int IW = (OW > LB) ? (OW - LB) : 1;      // word index bits

  // Burst type carries no meaning here: addresses arrive with every beat.
  logic unused_hburst;
  assign unused_hburst = ^i_hburst;

  // ---------------- address-phase decode ----------------
  logic [31:0] off;
  logic        accept, range_err, size_err, align_err, addr_err;

  assign off       = i_haddr - BASE_ADDR;             // wraps high when below base
  assign accept    = i_hready & i_hsel &
                     ((i_htrans == HTRANS_NONSEQ) | (i_htrans == HTRANS_SEQ));
  assign range_err = (off >= 32'(MEM_BYTES));
  assign size_err  = ((32'd1 << i_hsize) > 32'(NB));
  assign align_err = |(i_haddr[6:0] & ((7'd1 << i_hsize) - 7'd1));
  assign addr_err  = range_err | size_err | align_err;

  // ---------------- data-phase register + FSM ----------------
  t_slv_state    state_q;
  logic [3:0]    cnt_q;
  logic          hready_q;
  t_hresp        hresp_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic [OW-1:0] off_q;

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      write_q  <= 1'b0;
      size_q   <= '0;
      off_q    <= '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q  <= S_DATA;
            hready_q <= 1'b1;
          end
          cnt_q <= cnt_q - 4'd1;
        end
        S_ERR1: begin
          state_q  <= S_ERR2;
          hready_q <= 1'b1;
        end
        default: begin
          // S_IDLE, S_DATA, S_ERR2: bus is ready, a new beat may start.
          state_q  <= S_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
          if (accept) begin
            write_q <= i_hwrite;
            size_q  <= i_hsize;
            off_q   <= off[OW-1:0];
            if (addr_err) begin
              state_q  <= S_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state_q  <= S_WAIT;
              hready_q <= 1'b0;
              cnt_q    <= 4'(WAIT_STATES);
            end else begin
              state_q  <= S_DATA;
            end
          end
        end
      endcase
    end
  end

  // ---------------- byte lanes ----------------
  int          lane, nbytes;
  logic [NB-1:0] be_d;

  always_comb begin
    lane   = int'(off_q) % NB;
    nbytes = hsize_bytes(size_q);
    be_d   = '0;
    for (int b = 0; b < NB; b++) be_d[b] = (b >= lane) && (b < lane + nbytes);
  end

  // A beat still in flight when reset hits is dropped, never written.
  logic [NB-1:0]       ram_we;
  logic [IW-1:0]       ram_addr;
  logic [DATA_WDT-1:0] ram_rdata;

  assign ram_we = (state_q == S_DATA && write_q && !i_hreset) ? be_d : '0;

  if (OW > LB) begin : g_idx
    assign ram_addr = off_q[OW-1:LB];
  end else begin : g_idx_one
    assign ram_addr = '0;
  end

  ahb_slave_ram #(
    .DATA_WDT (DATA_WDT),
    .ADDR_W   (IW)
  ) u_ram (
    .i_clk   (i_hclk),
    .i_we    (ram_we),
    .i_addr  (ram_addr),
    .i_wdata (i_hwdata),
    .o_rdata (ram_rdata)
  );

  assign o_hready = hready_q;
  assign o_hresp  = hresp_q;
  assign o_hrdata = (state_q == S_DATA) ? ram_rdata : '0;

endmodule

// File: tb/tb_ahb_slave_sram.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_sram
//  Two responders share one stimulus bus: u0 with no wait states, u1 with
//  three. A pipelined master task plays vector tables, then random beats
//  scored against a byte-array memory model.
// ---------------------------------------------------------------------------
module tb_ahb_slave_sram;
  import ahb_master_pack::*;

  localparam int MEM = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        hsel;
  t_htrans     htrans;
  logic        hwrite;
  logic [31:0] haddr;
  t_hsize      hsize;
  t_hburst     hburst;
  logic [31:0] hwdata;
  logic        rdy0, rdy1, rdy;
  t_hresp      resp0, resp1, resp;
  logic [31:0] rd0, rd1, rd;
  logic        hsel0, hsel1;

  always #5 clk = ~clk;

  assign hsel0 = hsel & ~sel;
  assign hsel1 = hsel & sel;
  assign rdy   = sel ? rdy1  : rdy0;
  assign resp  = sel ? resp1 : resp0;
  assign rd    = sel ? rd1   : rd0;

  ahb_slave_sram #(.DATA_WDT(32), .MEM_BYTES(MEM), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u0 (
    .i_hclk(clk), .i_hreset(rst), .i_hsel(hsel0), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hwdata(hwdata),
    .i_hready(rdy0), .o_hready(rdy0), .o_hresp(resp0), .o_hrdata(rd0));

  ahb_slave_sram #(.DATA_WDT(32), .MEM_BYTES(MEM), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u1 (
    .i_hclk(clk), .i_hreset(rst), .i_hsel(hsel1), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hwdata(hwdata),
    .i_hready(rdy1), .o_hready(rdy1), .o_hresp(resp1), .o_hrdata(rd1));

  typedef struct {
    int          grp;
    int          dut;
    logic        hsel;
    t_htrans     trans;
    logic        wr;
    logic [31:0] addr;
    t_hsize      size;
    t_hburst     burst;
    logic [31:0] wdata;
    logic        dir;      // expectations below come from the table
    logic        e_err;
    logic        e_chk;    // compare read data against e_rdata
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // memory model: one byte array per responder, plus "written yet" flags
  logic [7:0] mm [2][MEM];
  bit         kn [2][MEM];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic bit m_err(input logic [31:0] a, input t_hsize s);
    longint ai = longint'(a);
    int     sz = 1 << s;
    if (ai >= MEM) return 1'b1;
    if (sz > 4) return 1'b1;
    if ((ai % sz) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_write(input int d, input logic [31:0] a, input t_hsize s, input logic [31:0] wd);
    int o = int'(a);
    for (int i = 0; i < (1 << s); i++) begin
      mm[d][o+i] = wd[8*((o % 4) + i) +: 8];
      kn[d][o+i] = 1'b1;
    end
  endtask

  task automatic m_read(input int d, input logic [31:0] a, output logic [31:0] e, output logic [31:0] m);
    int b = int'(a) & ~3;
    for (int i = 0; i < 4; i++) begin
      e[8*i +: 8] = mm[d][b+i];
      m[8*i +: 8] = kn[d][b+i] ? 8'hFF : 8'h00;
    end
  endtask

  task automatic add(input int g, input int d, input logic hs, input t_htrans t, input logic w,
                     input logic [31:0] a, input t_hsize s, input t_hburst b, input logic [31:0] wd,
                     input logic ee, input logic ec, input logic [31:0] er);
    vec_t v;
    v.grp = g; v.dut = d; v.hsel = hs; v.trans = t; v.wr = w; v.addr = a; v.size = s;
    v.burst = b; v.wdata = wd; v.dir = 1'b1; v.e_err = ee; v.e_chk = ec; v.e_rdata = er;
    tbl.push_back(v);
  endtask

  // Pipelined master: beat k's address phase overlaps beat k-1's data phase.
  task automatic run(input int d, input vec_t v[$]);
    int          n = v.size();
    int          ap = 0, dp = -1, waits = 0, cyc = 0, expw;
    logic        acc = 1'b0, cerr = 1'b0, now_rdy;
    logic [31:0] e, m;
    sel = (d != 0);
    while (ap <= n) begin
      now_rdy = rdy;
      if (ap < n) begin
        hsel = v[ap].hsel; htrans = v[ap].trans; hwrite = v[ap].wr;
        haddr = v[ap].addr; hsize = v[ap].size; hburst = v[ap].burst;
      end else begin
        hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
      end
      // Junk on hwdata during stall cycles: it must not be written.
      if (dp >= 0 && dp < n && v[dp].wr && now_rdy) hwdata = v[dp].wdata;
      else hwdata = $urandom;
      @(negedge clk);
      if (dp >= 0 && dp < n) begin
        if (!rdy) begin
          waits++;
          chk($sformatf("d%0d beat%0d stall resp", d, dp), 32'(resp), cerr ? 32'(HRESP_ERROR) : 32'(HRESP_OKAY));
          chk($sformatf("d%0d beat%0d stall rdata", d, dp), rd, 32'h0);
        end else begin
          expw = cerr ? 1 : (acc ? (d != 0 ? 3 : 0) : 0);
          chk($sformatf("d%0d beat%0d waits", d, dp), 32'(waits), 32'(expw));
          chk($sformatf("d%0d beat%0d resp", d, dp), 32'(resp), cerr ? 32'(HRESP_ERROR) : 32'(HRESP_OKAY));
          if (v[dp].dir) begin
            if (v[dp].e_chk) chk($sformatf("d%0d beat%0d rdata", d, dp), rd, v[dp].e_rdata);
          end else if (!acc || cerr) begin
            chk($sformatf("d%0d beat%0d rdata0", d, dp), rd, 32'h0);
          end else if (!v[dp].wr) begin
            m_read(d, v[dp].addr, e, m);
            chk($sformatf("d%0d beat%0d rdata", d, dp), rd & m, e & m);
          end
          if (acc && !m_err(v[dp].addr, v[dp].size) && v[dp].wr)
            m_write(d, v[dp].addr, v[dp].size, v[dp].wdata);
        end
      end
      if (rdy) begin
        dp = ap; ap++; waits = 0;
        if (dp < n) begin
          acc  = v[dp].hsel && (v[dp].trans == HTRANS_NONSEQ || v[dp].trans == HTRANS_SEQ);
          cerr = v[dp].dir ? v[dp].e_err : (acc && m_err(v[dp].addr, v[dp].size));
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 8 * (n + 2)) begin
        chk($sformatf("d%0d timeout", d), 32'(cyc), 32'(8 * (n + 2)));
        break;
      end
    end
  endtask

  task automatic run_group(input int g);
    vec_t q[$];
    int   d = 0;
    foreach (tbl[i]) if (tbl[i].grp == g) begin q.push_back(tbl[i]); d = tbl[i].dut; end
    run(d, q);
  endtask

  initial begin
    vec_t q[$];
    vec_t r;
    int   s;
    logic [31:0] raw;

    // ---- vector table ----
    // g0: back-to-back write/read, no waits
    add(0, 0, 1, HTRANS_NONSEQ, 1, 32'h10, HSIZE_32, HBURST_SINGLE, 32'hDEADBEEF, 0, 0, 0);
    add(0, 0, 1, HTRANS_NONSEQ, 0, 32'h10, HSIZE_32, HBURST_SINGLE, 32'h0, 0, 1, 32'hDEADBEEF);
    // g1: three wait states, preload then INCR4 read
    for (int i = 0; i < 4; i++)
      add(1, 1, 1, i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, 1, 32'h20 + 32'(4*i), HSIZE_32, HBURST_INCR4,
          32'hA0A0_0001 + 32'(i), 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(1, 1, 1, i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, 0, 32'h20 + 32'(4*i), HSIZE_32, HBURST_INCR4,
          32'h0, 0, 1, 32'hA0A0_0001 + 32'(i));
    add(1, 1, 1, HTRANS_NONSEQ, 1, 32'h80, HSIZE_32, HBURST_SINGLE, 32'h12345678, 0, 0, 0);
    // g2: byte / halfword lanes
    add(2, 0, 1, HTRANS_NONSEQ, 1, 32'h40, HSIZE_32, HBURST_SINGLE, 32'h11223344, 0, 0, 0);
    add(2, 0, 1, HTRANS_NONSEQ, 1, 32'h43, HSIZE_8,  HBURST_SINGLE, 32'hAA000000, 0, 0, 0);
    add(2, 0, 1, HTRANS_NONSEQ, 0, 32'h40, HSIZE_32, HBURST_SINGLE, 32'h0, 0, 1, 32'hAA223344);
    add(2, 0, 1, HTRANS_NONSEQ, 1, 32'h44, HSIZE_32, HBURST_SINGLE, 32'h00000000, 0, 0, 0);
    add(2, 0, 1, HTRANS_NONSEQ, 1, 32'h46, HSIZE_16, HBURST_SINGLE, 32'hBEEF0000, 0, 0, 0);
    add(2, 0, 1, HTRANS_NONSEQ, 0, 32'h44, HSIZE_32, HBURST_SINGLE, 32'h0, 0, 1, 32'hBEEF0000);
    // g3: error beats, next beat accepted during ERR2, IDLE during ERR2
    add(3, 0, 1, HTRANS_NONSEQ, 1, 32'h00, HSIZE_32, HBURST_SINGLE, 32'h01020304, 0, 0, 0);
    add(3, 0, 1, HTRANS_NONSEQ, 0, 32'h1000, HSIZE_32, HBURST_SINGLE, 32'h0, 1, 1, 32'h0);
    add(3, 0, 1, HTRANS_NONSEQ, 1, 32'h01, HSIZE_16, HBURST_SINGLE, 32'hFFFFFFFF, 1, 1, 32'h0);
    add(3, 0, 1, HTRANS_NONSEQ, 0, 32'h00, HSIZE_32, HBURST_SINGLE, 32'h0, 0, 1, 32'h01020304);
    add(3, 0, 1, HTRANS_NONSEQ, 0, 32'hFFFFFFFC, HSIZE_32, HBURST_SINGLE, 32'h0, 1, 1, 32'h0);
    add(3, 0, 1, HTRANS_IDLE, 0, 32'h0, HSIZE_32, HBURST_SINGLE, 32'h0, 0, 1, 32'h0);
    add(3, 0, 1, HTRANS_NONSEQ, 0, 32'h10, HSIZE_64, HBURST_SINGLE, 32'h0, 1, 1, 32'h0);
    add(3, 0, 1, HTRANS_NONSEQ, 0, 32'h40, HSIZE_32, HBURST_SINGLE, 32'h0, 0, 1, 32'hAA223344);
    // g4: BUSY mid INCR burst, unselected NONSEQ write
    add(4, 0, 1, HTRANS_NONSEQ, 1, 32'h108, HSIZE_32, HBURST_SINGLE, 32'h55AA55AA, 0, 0, 0);
    add(4, 0, 1, HTRANS_NONSEQ, 1, 32'h100, HSIZE_32, HBURST_INCR, 32'h11111111, 0, 0, 0);
    add(4, 0, 1, HTRANS_BUSY,   1, 32'h104, HSIZE_32, HBURST_INCR, 32'hDEADDEAD, 0, 1, 32'h0);
    add(4, 0, 1, HTRANS_SEQ,    1, 32'h104, HSIZE_32, HBURST_INCR, 32'h22222222, 0, 0, 0);
    add(4, 0, 0, HTRANS_NONSEQ, 1, 32'h108, HSIZE_32, HBURST_SINGLE, 32'h0BAD0BAD, 0, 1, 32'h0);
    add(4, 0, 1, HTRANS_NONSEQ, 0, 32'h100, HSIZE_32, HBURST_SINGLE, 32'h0, 0, 1, 32'h11111111);
    add(4, 0, 1, HTRANS_NONSEQ, 0, 32'h104, HSIZE_32, HBURST_SINGLE, 32'h0, 0, 1, 32'h22222222);
    add(4, 0, 1, HTRANS_NONSEQ, 0, 32'h108, HSIZE_32, HBURST_SINGLE, 32'h0, 0, 1, 32'h55AA55AA);
    // g5: after the reset pulse, the stalled write must not have landed
    add(5, 1, 1, HTRANS_NONSEQ, 0, 32'h80, HSIZE_32, HBURST_SINGLE, 32'h0, 0, 1, 32'h12345678);

    // ---- reset ----
    rst = 1'b1; sel = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    haddr = '0; hsize = HSIZE_32; hburst = HBURST_SINGLE; hwdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset hready0", 32'(rdy0), 32'h1);
    chk("reset hresp0", 32'(resp0), 32'(HRESP_OKAY));
    chk("reset hrdata0", rd0, 32'h0);
    chk("reset hready1", 32'(rdy1), 32'h1);
    chk("reset hresp1", 32'(resp1), 32'(HRESP_OKAY));
    chk("reset hrdata1", rd1, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    for (int g = 0; g <= 4; g++) run_group(g);

    // ---- reset while a write to 0x80 sits in S_WAIT on u1 ----
    sel = 1'b1;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h80; hsize = HSIZE_32;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("stalled write hready", 32'(rdy1), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post-reset hready", 32'(rdy1), 32'h1);
    chk("post-reset hresp", 32'(resp1), 32'(HRESP_OKAY));
    chk("post-reset hrdata", rd1, 32'h0);
    @(posedge clk); #1;
    run_group(5);

    // ---- random beats vs model ----
    for (int d = 0; d < 2; d++) begin
      q.delete();
      for (int i = 0; i < 150; i++) begin
        r.grp = 9; r.dut = d; r.dir = 1'b0; r.e_err = 1'b0; r.e_chk = 1'b0; r.e_rdata = '0;
        r.hsel = ($urandom_range(0, 9) != 0);
        s = int'($urandom_range(0, 9));
        r.trans = (s == 0) ? HTRANS_IDLE : (s == 1) ? HTRANS_BUSY :
                  (s < 6) ? HTRANS_NONSEQ : HTRANS_SEQ;
        r.wr    = $urandom_range(0, 1) == 1;
        r.size  = t_hsize'(($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2));
        r.burst = t_hburst'($urandom_range(0, 7));
        r.wdata = $urandom;
        s = int'($urandom_range(0, 19));
        raw = (s == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) :
              (s == 1) ? 32'hFFFFFF00 + 32'($urandom_range(0, 255)) :
                         32'($urandom_range(0, 255));
        if ($urandom_range(0, 7) != 0) raw = raw & ~((32'd1 << r.size) - 32'd1);
        r.addr = raw;
        q.push_back(r);
      end
      run(d, q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
